// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage MIPS core.
// Drives hold (enable-gated keep) and clear (bubble insert) controls for the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers plus the PC hold.  It resolves
// data-memory wait states, multi-cycle mul/div occupancy of EX, taken-branch
// flushes and load-use hazards, in that priority order.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> adds the 32-bit saturating stall_cycles output, counting
//                every cycle with hold_pc=1 outside reset.
//   undefined -> port and counter are absent; all other behaviour identical.
//
// MD_STALL (1..15) is the number of stall cycles a mul/div costs.
module hazard_ctrl #(
  parameter int unsigned MD_STALL = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  input  logic        mem_wait,
  output logic        hold_pc,
  output logic        hold_ifid,
  output logic        hold_idex,
  output logic        hold_exmem,
  output logic        clr_ifid,
  output logic        clr_idex,
  output logic        clr_exmem,
  output logic        clr_memwb
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  // The first stall cycle is spent in RUN, so MD_BUSY covers MD_STALL-1
  // cycles: the counter is loaded with MD_STALL-2 and exits when it hits 0.
  localparam int          CNT_INIT_I = (MD_STALL >= 2) ? (int'(MD_STALL) - 2) : 0;
  localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];
  localparam logic        MD_SINGLE  = (MD_STALL == 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        md_done_q, md_done_d;

  logic        md_trigger;
  logic        md_stall;
  logic        load_use;
  logic        rs_match;
  logic        rt_match;

  // Hazard detection terms.
  always_comb begin
    md_trigger = (state_q == RUN) && ex_md_start && !md_done_q;
    md_stall   = md_trigger || (state_q == MD_BUSY);
    rs_match   = (ex_rd == id_rs);
    rt_match   = id_use_rt && (ex_rd == id_rt);
    load_use   = ex_memread && (ex_rd != 5'd0) && (rs_match || rt_match);
  end

  // Prioritised pipeline control; never holds and clears the same register.
  always_comb begin
    hold_pc    = 1'b0;
    hold_ifid  = 1'b0;
    hold_idex  = 1'b0;
    hold_exmem = 1'b0;
    clr_ifid   = 1'b0;
    clr_idex   = 1'b0;
    clr_exmem  = 1'b0;
    clr_memwb  = 1'b0;
    if (reset) begin
      clr_ifid  = 1'b1;
      clr_idex  = 1'b1;
      clr_exmem = 1'b1;
      clr_memwb = 1'b1;
    end else if (mem_wait) begin
      // Freeze everything upstream of MEM/WB; the stalled MEM stage must not
      // retire, so WB receives a bubble.
      hold_pc    = 1'b1;
      hold_ifid  = 1'b1;
      hold_idex  = 1'b1;
      hold_exmem = 1'b1;
      clr_memwb  = 1'b1;
    end else if (md_stall) begin
      // mul/div keeps EX busy: freeze the front end, bubble into MEM.
      hold_pc   = 1'b1;
      hold_ifid = 1'b1;
      hold_idex = 1'b1;
      clr_exmem = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the two wrong-path instructions in IF and ID.
      clr_ifid = 1'b1;
      clr_idex = 1'b1;
    end else if (load_use) begin
      // Keep the consumer in ID one cycle, bubble into EX.
      hold_pc   = 1'b1;
      hold_ifid = 1'b1;
      clr_idex  = 1'b1;
    end
  end

  // Next-state logic for the mul/div occupancy tracker; frozen on mem_wait.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_done_d = md_done_q;
    if (!mem_wait) begin
      // md_done only lives for one non-wait cycle, long enough to stop the
      // departing mul/div from retriggering while ex_md_start is still high.
      md_done_d = 1'b0;
      case (state_q)
        RUN: begin
          if (md_trigger) begin
            if (MD_SINGLE) begin
              md_done_d = 1'b1;
            end else begin
              state_d = MD_BUSY;
              cnt_d   = CNT_INIT;
            end
          end
        end
        MD_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_d   = RUN;
            md_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset abandons any mul/div stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= 4'd0;
      md_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_done_q <= md_done_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (hold_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.  Two instances share the
// stimulus: u_dut with MD_STALL=3 and u_dut1 with MD_STALL=1.
// Output vectors are packed as
//   {hold_pc, hold_ifid, hold_idex, hold_exmem,
//    clr_ifid, clr_idex, clr_exmem, clr_memwb}
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rt, ex_memread, ex_branch_taken, ex_md_start, mem_wait;

  logic hold_pc, hold_ifid, hold_idex, hold_exmem;
  logic clr_ifid, clr_idex, clr_exmem, clr_memwb;
  logic hold_pc1, hold_ifid1, hold_idex1, hold_exmem1;
  logic clr_ifid1, clr_idex1, clr_exmem1, clr_memwb1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, stall_cycles1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] IDLE  = 8'b0000_0000;
  localparam logic [7:0] RST   = 8'b0000_1111;
  localparam logic [7:0] LDU   = 8'b1100_0100;
  localparam logic [7:0] BRN   = 8'b0000_1100;
  localparam logic [7:0] MDS   = 8'b1110_0010;
  localparam logic [7:0] MWAIT = 8'b1111_0001;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_STALL(3)) u_dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .mem_wait(mem_wait),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .hold_idex(hold_idex),
    .hold_exmem(hold_exmem),
    .clr_ifid(clr_ifid), .clr_idex(clr_idex), .clr_exmem(clr_exmem),
    .clr_memwb(clr_memwb)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  hazard_ctrl #(.MD_STALL(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .mem_wait(mem_wait),
    .hold_pc(hold_pc1), .hold_ifid(hold_ifid1), .hold_idex(hold_idex1),
    .hold_exmem(hold_exmem1),
    .clr_ifid(clr_ifid1), .clr_idex(clr_idex1), .clr_exmem(clr_exmem1),
    .clr_memwb(clr_memwb1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles1)
`endif
  );

  logic [7:0] obs, obs1;
  assign obs  = {hold_pc, hold_ifid, hold_idex, hold_exmem,
                 clr_ifid, clr_idex, clr_exmem, clr_memwb};
  assign obs1 = {hold_pc1, hold_ifid1, hold_idex1, hold_exmem1,
                 clr_ifid1, clr_idex1, clr_exmem1, clr_memwb1};

  task automatic idle_inputs();
    reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1'b0;
    ex_memread = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
    ex_md_start = 1'b0; mem_wait = 1'b0;
  endtask

  // Settle, compare the MD_STALL=3 instance, then advance one clock.
  task automatic cyc(input string tag, input logic [7:0] exp);
    #2;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("[TB] %-14s obs=%b exp=%b", tag, obs, exp);
    @(posedge clk); #1;
  endtask

  // Same as cyc but also compares the MD_STALL=1 instance.
  task automatic cyc2(input string tag, input logic [7:0] exp, input logic [7:0] exp1);
    #2;
    n_tests++;
    assert (obs1 === exp1) else begin
      n_fail++;
      $error("FAIL %s_md1: observed %b expected %b", tag, obs1, exp1);
    end
    cyc(tag, exp);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    mem_wait = 1'b1;                     // reset outranks mem_wait
    #1;
    cyc2("reset_wait", RST, RST);
    mem_wait = 1'b0;
    cyc2("reset", RST, RST);
    reset = 1'b0;
    cyc2("idle", IDLE, IDLE);

    // Load-use on rs: exactly one stall cycle.
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    cyc("ldu_rs", LDU);
    idle_inputs();
    cyc("ldu_after", IDLE);

    // mul/div MD_STALL=3, start held 4 cycles: 3 stalls, no retrigger.
    ex_md_start = 1'b1;
    cyc("md_c1", MDS);
    cyc("md_c2", MDS);
    cyc("md_c3", MDS);
`ifdef HAZARD_PERF_CNT_EN
    #2;
    n_tests++;
    assert (stall_cycles === 32'd4) else begin
      n_fail++;
      $error("FAIL perf_cnt: observed %0d expected %0d", stall_cycles, 4);
    end
    $display("[TB] perf_cnt       obs=%0d exp=4", stall_cycles);
    #0;
`endif
    cyc("md_c4_noretrig", IDLE);
    ex_md_start = 1'b0;
    cyc("md_done", IDLE);

    // Load-use with rd=0 is never a hazard.
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
    cyc("ldu_r0", IDLE);
    // rt match only counts when id_use_rt is set.
    ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_use_rt = 1'b1;
    cyc("ldu_rt", LDU);
    id_use_rt = 1'b0;
    cyc("ldu_rt_unused", IDLE);
    // Not a load: no hazard even on a match.
    ex_memread = 1'b0; id_rs = 5'd7;
    cyc("no_load", IDLE);
    idle_inputs();

    // Taken branch: flush IF/ID and ID/EX, no holds.
    ex_branch_taken = 1'b1;
    cyc("branch", BRN);
    ex_branch_taken = 1'b0;
    cyc("branch_after", IDLE);

    // Branch outranks a simultaneous load-use.
    ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
    cyc("branch_ldu", BRN);
    idle_inputs();

    // mem_wait alone.
    mem_wait = 1'b1;
    cyc("mem_wait", MWAIT);
    mem_wait = 1'b0;
    cyc("mem_wait_end", IDLE);

    // mem_wait for 2 cycles inside MD_BUSY: 5 hold cycles in total.
    ex_md_start = 1'b1;
    cyc("mdw_c1", MDS);
    mem_wait = 1'b1;
    cyc("mdw_wait1", MWAIT);
    cyc("mdw_wait2", MWAIT);
    mem_wait = 1'b0;
    cyc("mdw_c2", MDS);
    cyc("mdw_c3", MDS);
    cyc("mdw_noretrig", IDLE);
    ex_md_start = 1'b0;
    cyc("mdw_done", IDLE);

    // MD_STALL=1 instance: a single stall cycle.
    reset = 1'b1;
    cyc2("reset2", RST, RST);
    reset = 1'b0;
    ex_md_start = 1'b1;
    cyc2("md1_c1", MDS, MDS);
    cyc2("md1_c2", MDS, IDLE);
    ex_md_start = 1'b0;
    cyc("md1_c3", MDS);
    cyc2("md1_end", IDLE, IDLE);

    // mul/div outranks a taken branch.
    ex_md_start = 1'b1; ex_branch_taken = 1'b1;
    cyc("md_over_branch", MDS);
    ex_branch_taken = 1'b0;
    cyc("mdb_c2", MDS);
    cyc("mdb_c3", MDS);
    cyc("mdb_noretrig", IDLE);
    ex_md_start = 1'b0;
    cyc("mdb_done", IDLE);

    // Reset while in MD_BUSY abandons the stall.
    ex_md_start = 1'b1;
    cyc("mdr_c1", MDS);
    ex_md_start = 1'b0;
    cyc("mdr_busy", MDS);
    reset = 1'b1;
    cyc("mdr_reset", RST);
    reset = 1'b0;
    cyc("mdr_after", IDLE);
    cyc("mdr_after2", IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
